jump_target_unit: RTL and testbench

- Next-PC generator for the core's fetch stage.
- Replaces the fixed jump-label mux with a runtime-writable label table, a call/return stack and a registered next-PC output.
- Each `step_i` selects one next PC (sequential, direct, label, call or return) and presents it one cycle later.
- Sits between decode, which supplies mode, label and direct target, and the PC register.

---
 rtl/jtu_pkg.sv | 32 +++
 rtl/jump_target_unit_if.sv | 37 +++
 rtl/jtu_ras.sv | 41 ++++
 rtl/jump_target_unit.sv | 123 ++++++++++++
 tb/tb_jump_target_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jtu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtu_pkg
// Brief    : Shared types, reset label table and helpers for jump_target_unit.
// Revision : 1.0
// ============================================================================
package jtu_pkg;

    typedef enum logic [2:0] {
        JTU_SEQ    = 3'd0,
        JTU_DIRECT = 3'd1,
        JTU_LABEL  = 3'd2,
        JTU_CALL   = 3'd3,
        JTU_RET    = 3'd4
    } jtu_mode_t;

    localparam int LBL_DEF_N = 16;

    localparam logic [15:0] LBL_DEFAULTS [LBL_DEF_N] = '{
        16'd10,  16'd22,  16'd102, 16'd152,
        16'd196, 16'd212, 16'd8,   16'd39,
        16'd18,  16'd46,  16'd83,  16'd60,
        16'd0,   16'd0,   16'd0,   16'd0
    };

    // Computed at full width; callers truncate to PC_W, which yields the wrap.
    function automatic logic [63:0] seq_pc(input logic [63:0] pc);
        return pc + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_target_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : jump_target_unit_if
// Brief    : Decode-side request and next-PC response bundle.
// Revision : 1.0
// ============================================================================
interface jump_target_unit_if #(
    parameter int PC_W  = 16,
    parameter int LBL_W = 4
);
    logic             step_i;
    logic [2:0]       mode_i;
    logic [PC_W-1:0]  pc_i;
    logic [PC_W-1:0]  direct_i;
    logic [LBL_W-1:0] label_i;
    logic             tbl_we_i;
    logic [LBL_W-1:0] tbl_waddr_i;
    logic [PC_W-1:0]  tbl_wdata_i;
    logic [PC_W-1:0]  next_pc_o;
    logic             next_pc_valid_o;
    logic             ras_full_o;
    logic             ras_empty_o;
    logic             fault_o;

    modport master (
        output step_i, mode_i, pc_i, direct_i, label_i,
               tbl_we_i, tbl_waddr_i, tbl_wdata_i,
        input  next_pc_o, next_pc_valid_o, ras_full_o, ras_empty_o, fault_o
    );

    modport slave (
        input  step_i, mode_i, pc_i, direct_i, label_i,
               tbl_we_i, tbl_waddr_i, tbl_wdata_i,
        output next_pc_o, next_pc_valid_o, ras_full_o, ras_empty_o, fault_o
    );
endinterface
`default_nettype wire

// File: rtl/jtu_ras.sv
`default_nettype none
// ============================================================================
// Module   : jtu_ras
// Brief    : Return-address LIFO; flags derive from the registered count.
// Revision : 1.0
// ============================================================================
module jtu_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_push_data,
    output logic      [WIDTH-1:0] o_top,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_cnt;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_top   = r_mem[AW'(r_cnt - CW'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_mem[AW'(r_cnt)] <= i_push_data;
            r_cnt             <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/jump_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : jump_target_unit
// Brief    : Registered next-PC generator with label table and return stack.
// Revision : 1.0
// ============================================================================
module jump_target_unit
    import jtu_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int LBL_W     = 4,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    jump_target_unit_if.slave bus
);
    localparam int TBL_DEPTH = 2 ** LBL_W;

    logic [PC_W-1:0] r_tbl [TBL_DEPTH];
    logic [PC_W-1:0] w_def [TBL_DEPTH];
    logic [PC_W-1:0] r_next_pc;
    logic            r_valid;
    logic            r_fault;

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_tbl_rd;
    logic [PC_W-1:0] w_ras_top;
    logic [PC_W-1:0] w_next;
    logic            w_push;
    logic            w_pop;
    logic            w_fault;
    logic            w_full;
    logic            w_empty;

    for (genvar gi = 0; gi < TBL_DEPTH; gi++) begin : g_def
        if (gi < LBL_DEF_N) begin : g_rom
            assign w_def[gi] = PC_W'(LBL_DEFAULTS[gi]);
        end else begin : g_zero
            assign w_def[gi] = '0;
        end
    end

    // Table read is taken from the register, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                r_tbl[i] <= w_def[i];
            end
        end else if (bus.tbl_we_i) begin
            r_tbl[bus.tbl_waddr_i] <= bus.tbl_wdata_i;
        end
    end

    assign w_seq    = PC_W'(seq_pc(64'(bus.pc_i)));
    assign w_tbl_rd = r_tbl[bus.label_i];

    always_comb begin
        w_next  = w_seq;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_fault = 1'b0;
        case (jtu_mode_t'(bus.mode_i))
            JTU_SEQ:    w_next = w_seq;
            JTU_DIRECT: w_next = bus.direct_i;
            JTU_LABEL:  w_next = w_tbl_rd;
            JTU_CALL: begin
                if (w_full) begin
                    w_fault = 1'b1;
                end else begin
                    w_push = bus.step_i;
                    w_next = w_tbl_rd;
                end
            end
            JTU_RET: begin
                if (w_empty) begin
                    w_fault = 1'b1;
                end else begin
                    w_pop  = bus.step_i;
                    w_next = w_ras_top;
                end
            end
            default: w_fault = 1'b1;
        endcase
    end

    jtu_ras #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_seq),
        .o_top       (w_ras_top),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_next_pc <= '0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_valid <= bus.step_i;
            if (bus.step_i) begin
                r_next_pc <= w_next;
                if (w_fault) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    assign bus.next_pc_o       = r_next_pc;
    assign bus.next_pc_valid_o = r_valid;
    assign bus.ras_full_o      = w_full;
    assign bus.ras_empty_o     = w_empty;
    assign bus.fault_o         = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_jump_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_target_unit
// Brief    : Directed self-checking bench for jump_target_unit.
// Revision : 1.0
// ============================================================================
module tb_jump_target_unit;
    localparam int PC_W      = 16;
    localparam int LBL_W     = 4;
    localparam int RAS_DEPTH = 4;

    localparam logic [2:0] M_SEQ = 3'd0, M_DIR = 3'd1, M_LBL = 3'd2,
                           M_CALL = 3'd3, M_RET = 3'd4, M_RSV = 3'd6;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jump_target_unit_if #(.PC_W(PC_W), .LBL_W(LBL_W)) bus ();

    jump_target_unit #(
        .PC_W      (PC_W),
        .LBL_W     (LBL_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one request across one rising edge, then sample 1 time unit later.
    task automatic step(input logic [2:0] mode, input logic [15:0] pc,
                        input logic [15:0] dir, input logic [3:0] lbl);
        bus.step_i   = 1'b1;
        bus.mode_i   = mode;
        bus.pc_i     = pc;
        bus.direct_i = dir;
        bus.label_i  = lbl;
        @(posedge clk);
        #1;
        bus.step_i   = 1'b0;
        bus.tbl_we_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.step_i      = 1'b0;
        bus.mode_i      = M_SEQ;
        bus.pc_i        = '0;
        bus.direct_i    = '0;
        bus.label_i     = '0;
        bus.tbl_we_i    = 1'b0;
        bus.tbl_waddr_i = '0;
        bus.tbl_wdata_i = '0;
        do_reset();

        chk("rst_next_pc", 32'(bus.next_pc_o), 32'd0);
        chk("rst_valid",   32'(bus.next_pc_valid_o), 32'd0);
        chk("rst_fault",   32'(bus.fault_o), 32'd0);
        chk("rst_empty",   32'(bus.ras_empty_o), 32'd1);
        chk("rst_full",    32'(bus.ras_full_o), 32'd0);

        step(M_LBL, 16'd0, 16'd0, 4'd7);
        chk("lbl7", 32'(bus.next_pc_o), 32'd39);
        chk("lbl7_valid", 32'(bus.next_pc_valid_o), 32'd1);
        idle();
        chk("valid_pulse_end", 32'(bus.next_pc_valid_o), 32'd0);
        step(M_LBL, 16'd0, 16'd0, 4'd12);
        chk("lbl12", 32'(bus.next_pc_o), 32'd0);

        step(M_DIR, 16'd0, 16'h5555, 4'd0);
        chk("direct_5555", 32'(bus.next_pc_o), 32'h5555);
        step(M_SEQ, 16'hFFFF, 16'd0, 4'd0);
        chk("seq_wrap", 32'(bus.next_pc_o), 32'h0000);
        step(M_DIR, 16'd0, 16'h1234, 4'd0);
        chk("direct_1234", 32'(bus.next_pc_o), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("hold_value", 32'(bus.next_pc_o), 32'h1234);
            chk("hold_valid", 32'(bus.next_pc_valid_o), 32'd0);
        end

        bus.tbl_we_i    = 1'b1;
        bus.tbl_waddr_i = 4'd2;
        bus.tbl_wdata_i = 16'd500;
        step(M_LBL, 16'd0, 16'd0, 4'd2);
        chk("rbw_old", 32'(bus.next_pc_o), 32'd102);
        step(M_LBL, 16'd0, 16'd0, 4'd2);
        chk("rbw_new", 32'(bus.next_pc_o), 32'd500);

        // Write-only cycle restores label 2 before the call sequence.
        bus.tbl_we_i    = 1'b1;
        bus.tbl_wdata_i = 16'd102;
        idle();
        bus.tbl_we_i    = 1'b0;

        step(M_CALL, 16'd100, 16'd0, 4'd0);
        chk("call0", 32'(bus.next_pc_o), 32'd10);
        chk("call0_empty", 32'(bus.ras_empty_o), 32'd0);
        step(M_CALL, 16'd200, 16'd0, 4'd1);
        chk("call1", 32'(bus.next_pc_o), 32'd22);
        step(M_CALL, 16'd300, 16'd0, 4'd2);
        chk("call2", 32'(bus.next_pc_o), 32'd102);
        chk("call2_full", 32'(bus.ras_full_o), 32'd0);
        step(M_CALL, 16'd400, 16'd0, 4'd3);
        chk("call3", 32'(bus.next_pc_o), 32'd152);
        chk("call3_full", 32'(bus.ras_full_o), 32'd1);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret0", 32'(bus.next_pc_o), 32'd401);
        chk("ret0_full", 32'(bus.ras_full_o), 32'd0);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret1", 32'(bus.next_pc_o), 32'd301);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret2", 32'(bus.next_pc_o), 32'd201);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret3", 32'(bus.next_pc_o), 32'd101);
        chk("ret3_empty", 32'(bus.ras_empty_o), 32'd1);
        chk("ret3_fault", 32'(bus.fault_o), 32'd0);

        step(M_CALL, 16'd10, 16'd0, 4'd4);
        chk("call4", 32'(bus.next_pc_o), 32'd196);
        step(M_CALL, 16'd20, 16'd0, 4'd5);
        chk("call5", 32'(bus.next_pc_o), 32'd212);
        step(M_CALL, 16'd30, 16'd0, 4'd6);
        chk("call6", 32'(bus.next_pc_o), 32'd8);
        step(M_CALL, 16'd40, 16'd0, 4'd7);
        chk("call7", 32'(bus.next_pc_o), 32'd39);
        chk("refill_fault", 32'(bus.fault_o), 32'd0);
        step(M_CALL, 16'd50, 16'd0, 4'd0);
        chk("call_full_pc", 32'(bus.next_pc_o), 32'd51);
        chk("call_full_fault", 32'(bus.fault_o), 32'd1);
        chk("call_full_still", 32'(bus.ras_full_o), 32'd1);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret_a", 32'(bus.next_pc_o), 32'd41);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret_b", 32'(bus.next_pc_o), 32'd31);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret_c", 32'(bus.next_pc_o), 32'd21);
        step(M_RET, 16'd0, 16'd0, 4'd0);
        chk("ret_d", 32'(bus.next_pc_o), 32'd11);
        chk("fault_sticky", 32'(bus.fault_o), 32'd1);
        step(M_RET, 16'd9, 16'd0, 4'd0);
        chk("ret_empty_pc", 32'(bus.next_pc_o), 32'd10);
        chk("ret_empty_flag", 32'(bus.ras_empty_o), 32'd1);
        chk("ret_empty_fault", 32'(bus.fault_o), 32'd1);

        do_reset();
        chk("rst2_fault", 32'(bus.fault_o), 32'd0);
        step(M_RSV, 16'd9, 16'd0, 4'd0);
        chk("rsv_pc", 32'(bus.next_pc_o), 32'd10);
        chk("rsv_fault", 32'(bus.fault_o), 32'd1);
        chk("rsv_empty", 32'(bus.ras_empty_o), 32'd1);

        do_reset();
        bus.tbl_we_i    = 1'b1;
        bus.tbl_waddr_i = 4'd2;
        bus.tbl_wdata_i = 16'd777;
        step(M_CALL, 16'd60, 16'd0, 4'd1);
        chk("pre_rst_call", 32'(bus.next_pc_o), 32'd22);
        rst_n = 1'b0;
        step(M_CALL, 16'd70, 16'd0, 4'd3);
        rst_n = 1'b1;
        chk("rst_step_valid", 32'(bus.next_pc_valid_o), 32'd0);
        chk("rst_step_pc", 32'(bus.next_pc_o), 32'd0);
        chk("rst_step_empty", 32'(bus.ras_empty_o), 32'd1);
        step(M_LBL, 16'd0, 16'd0, 4'd2);
        chk("tbl_restored", 32'(bus.next_pc_o), 32'd102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
